lstm_seq_ctrl: RTL and testbench
================================

Name: lstm_seq_ctrl

Overview:
Sequencer that sits directly upstream of lstm_cell and drives it for one timestep at a time. It accepts an input vector x(t) as a valid/ready stream and drives the cell's acc_x/acc_h strobes, operands and weight index. It supplies h(t-1) from an internal recurrent buffer and c(t-1) from a state register. After the cell's pipeline settles it captures the cell's c(t) and h(t) and presents them on a valid/ready output.

Parameters:
WIDTH, 32, data word width (signed fixed point)
FRAC, 24, fractional bits (1.0 = 1<<FRAC)
NUM_X, 4, input vector length per timestep
NUM_H, 1, recurrent vector length (h buffer depth)
SELF_IDX, 0, h-buffer entry overwritten by this cell's own h at capture
CELL_LAT, 3, cycles from last acc beat until cell o_c/o_h are valid
AW, 8, weight index width (>= clog2(NUM_X+NUM_H))

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_x_valid  in  1  x stream beat valid
i_x  in  WIDTH  x stream data
o_x_ready  out  1  x beat accepted when high with i_x_valid
i_clear  in  1  zero state register and h buffer (new sequence)
i_h_wr  in  1  external h-buffer write strobe
i_h_addr  in  clog2(NUM_H)  external write address
i_h_data  in  WIDTH  external write data
o_acc_x  out  1  to cell acc_x
o_acc_h  out  1  to cell acc_h
o_cell_x  out  WIDTH  to cell i_x
o_cell_h  out  WIDTH  to cell i_h
o_prev_state  out  WIDTH  to cell i_prev_state (state register)
o_w_addr  out  AW  weight/U memory index for current beat
i_cell_c  in  WIDTH  from cell o_c
i_cell_h  in  WIDTH  from cell o_h
o_valid  out  1  captured result valid
i_ready  in  1  downstream accepts result
o_h  out  WIDTH  captured h(t)
o_c  out  WIDTH  captured c(t)
o_busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; state register, h buffer, counters 0.
- States: IDLE, ACC_X, ACC_H, WAIT, CAPT, OUT.
- IDLE: o_x_ready=0. If i_clear: zero state register and all h-buffer entries, stay in IDLE. Else if i_x_valid: go to ACC_X with beat counter k=0. i_clear is ignored outside IDLE.
- ACC_X: o_x_ready=1. o_acc_x = i_x_valid. o_cell_x = i_x. o_w_addr = k. k increments only on an accepted beat. A stall (valid low) holds k and deasserts acc_x. After beat k=NUM_X-1 is accepted: k=0, go to ACC_H.
- ACC_H: o_acc_h=1 every cycle, no stalls. o_cell_h = hbuf[k]. o_w_addr = NUM_X+k. After k=NUM_H-1, go to WAIT.
- WAIT: lat counter runs CELL_LAT cycles, then go to CAPT.
- CAPT (1 cycle): o_c <= i_cell_c; o_h <= i_cell_h; state register <= i_cell_c; hbuf[SELF_IDX] <= i_cell_h; go to OUT.
- OUT: o_valid=1. o_h/o_c are held stable until i_ready is seen high. On i_ready, drop o_valid and go to IDLE. A new timestep can start in the cycle after the handshake.
- Strobes and operands are combinational from state and counters. o_acc_x/o_acc_h are never high together.
- o_prev_state is constant from ACC_X entry through CAPT.
- External h writes: accepted in any state and take effect next cycle. A read in the same cycle returns the old value. If an external write hits SELF_IDX in the CAPT cycle, the external write wins.
- Timestep latency with no stalls: NUM_X + NUM_H + CELL_LAT + 1 cycles from the first x beat to o_valid.
- Reset mid-operation: abort immediately to reset values. A partial timestep is discarded.

Optional Feature:
LSTM_STATE_CLAMP_EN: when defined, the value written into the state register and o_c at CAPT saturates to the range [-(4<<FRAC), +(4<<FRAC)]. This bounds cell-state growth for the 8.24 format. When not defined, i_cell_c is captured unmodified.

Test Plan:
- NUM_X=4, NUM_H=1, CELL_LAT=3; x beats 1.0,2.0,3.0,4.0 back-to-back -> acc_x high 4 cycles with o_w_addr 0..3; acc_h 1 cycle with o_w_addr 4 and o_cell_h=0; o_valid 9 cycles after the first beat.
- Cell model returns c=0x00800000, h=0x00400000 -> o_c/o_h equal these. Next timestep: o_prev_state=0x00800000 and o_cell_h=0x00400000 during ACC_H.
- i_x_valid low for 2 cycles after beat 1 -> acc_x low for those cycles, k holds at 1, o_w_addr sequence unchanged, latency +2.
- i_ready held low 5 cycles in OUT -> o_valid and o_h/o_c stable for 5 cycles; accepted on the 6th; o_x_ready stays 0 throughout.
- i_clear in IDLE after a timestep -> o_prev_state=0 and hbuf all 0. rst asserted mid ACC_H -> all outputs 0 the next cycle, IDLE.
- With LSTM_STATE_CLAMP_EN, i_cell_c=0x07000000 -> captured 0x04000000. i_cell_c=0xF9000000 -> 0xFC000000. Without the macro, both values pass unmodified.

Source files
------------

// File: rtl/lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lstm_seq_ctrl
// Brief    : Timestep sequencer placed directly upstream of lstm_cell. Accepts
//            x(t) as a valid/ready stream, drives the cell's acc_x/acc_h beats
//            with operands and weight index, supplies h(t-1) from a recurrent
//            buffer and c(t-1) from a state register, then captures c(t)/h(t)
//            after the cell pipeline settles and offers them on valid/ready.
// Options  : LSTM_STATE_CLAMP_EN - saturate captured c(t) to +/-4.0
// Revision : 1.0 - initial release
// ============================================================================
module lstm_seq_ctrl #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 24,
    parameter int NUM_X    = 4,
    parameter int NUM_H    = 1,
    parameter int SELF_IDX = 0,
    parameter int CELL_LAT = 3,
    parameter int AW       = 8,
    localparam int HAW     = (NUM_H > 1) ? $clog2(NUM_H) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_x_valid,
    input  logic [WIDTH-1:0] i_x,
    output logic             o_x_ready,
    input  logic             i_clear,
    input  logic             i_h_wr,
    input  logic [HAW-1:0]   i_h_addr,
    input  logic [WIDTH-1:0] i_h_data,
    output logic             o_acc_x,
    output logic             o_acc_h,
    output logic [WIDTH-1:0] o_cell_x,
    output logic [WIDTH-1:0] o_cell_h,
    output logic [WIDTH-1:0] o_prev_state,
    output logic [AW-1:0]    o_w_addr,
    input  logic [WIDTH-1:0] i_cell_c,
    input  logic [WIDTH-1:0] i_cell_h,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_h,
    output logic [WIDTH-1:0] o_c,
    output logic             o_busy
);

    // WAIT counter only needs to reach CELL_LAT-1 (CELL_LAT >= 1 assumed)
    localparam int LW = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC_X = 3'd1,
        S_ACC_H = 3'd2,
        S_WAIT  = 3'd3,
        S_CAPT  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_k;
    logic [LW-1:0]    r_lat;
    logic [WIDTH-1:0] r_cstate;
    logic [WIDTH-1:0] r_hbuf [NUM_H];
    logic [WIDTH-1:0] r_h;
    logic [WIDTH-1:0] r_c;
    logic             r_valid;

    logic [WIDTH-1:0] w_hsel;
    logic [WIDTH-1:0] w_c_cap;

    // Recurrent operand for the current ACC_H beat (mux over the h buffer)
    always_comb begin
        w_hsel = '0;
        for (int i = 0; i < NUM_H; i++) begin
            if (r_k == AW'(i)) begin
                w_hsel = r_hbuf[i];
            end
        end
    end

`ifdef LSTM_STATE_CLAMP_EN
    localparam logic signed [WIDTH-1:0] C_CLAMP_MAX = WIDTH'(64'sd4 <<< FRAC);
    localparam logic signed [WIDTH-1:0] C_CLAMP_MIN = -C_CLAMP_MAX;

    // Saturate the captured cell state to [-4.0, +4.0] to bound its growth
    always_comb begin
        if ($signed(i_cell_c) > C_CLAMP_MAX) begin
            w_c_cap = C_CLAMP_MAX;
        end else if ($signed(i_cell_c) < C_CLAMP_MIN) begin
            w_c_cap = C_CLAMP_MIN;
        end else begin
            w_c_cap = i_cell_c;
        end
    end
`else
    assign w_c_cap = i_cell_c;
`endif

    // Cell-facing strobes and operands follow state and beat counter directly
    assign o_x_ready    = (r_state == S_ACC_X);
    assign o_acc_x      = (r_state == S_ACC_X) && i_x_valid;
    assign o_acc_h      = (r_state == S_ACC_H);
    assign o_cell_x     = (r_state == S_ACC_X) ? i_x : '0;
    assign o_cell_h     = (r_state == S_ACC_H) ? w_hsel : '0;
    assign o_w_addr     = (r_state == S_ACC_X) ? r_k :
                          (r_state == S_ACC_H) ? (AW'(NUM_X) + r_k) : '0;
    assign o_prev_state = r_cstate;
    assign o_busy       = (r_state != S_IDLE);
    assign o_valid      = r_valid;
    assign o_h          = r_h;
    assign o_c          = r_c;

    // Timestep sequencer: accumulate x, accumulate h, wait out cell latency,
    // capture results, then hold them until the downstream handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_lat    <= '0;
            r_cstate <= '0;
            r_h      <= '0;
            r_c      <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_k   <= '0;
                    r_lat <= '0;
                    if (i_clear) begin
                        r_cstate <= '0;
                    end else if (i_x_valid) begin
                        r_state <= S_ACC_X;
                    end
                end
                S_ACC_X: begin
                    // k advances only on accepted beats; stalls hold it
                    if (i_x_valid) begin
                        if (r_k == AW'(NUM_X - 1)) begin
                            r_k     <= '0;
                            r_state <= S_ACC_H;
                        end else begin
                            r_k <= r_k + AW'(1);
                        end
                    end
                end
                S_ACC_H: begin
                    if (r_k == AW'(NUM_H - 1)) begin
                        r_k     <= '0;
                        r_lat   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_k <= r_k + AW'(1);
                    end
                end
                S_WAIT: begin
                    if (r_lat == LW'(CELL_LAT - 1)) begin
                        r_lat   <= '0;
                        r_state <= S_CAPT;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                S_CAPT: begin
                    r_c      <= w_c_cap;
                    r_h      <= i_cell_h;
                    r_cstate <= w_c_cap;
                    r_valid  <= 1'b1;
                    r_state  <= S_OUT;
                end
                S_OUT: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Recurrent h buffer: clear in IDLE, own h at capture, and an external
    // write applied last so it overrides the capture on an address clash
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_H; i++) begin
                r_hbuf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_H; i++) begin
                if ((r_state == S_IDLE) && i_clear) begin
                    r_hbuf[i] <= '0;
                end
                if ((r_state == S_CAPT) && (i == SELF_IDX)) begin
                    r_hbuf[i] <= i_cell_h;
                end
                if (i_h_wr && (i_h_addr == HAW'(i))) begin
                    r_hbuf[i] <= i_h_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lstm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lstm_seq_ctrl
// Brief    : Self-checking bench for lstm_seq_ctrl. A timestep-level model
//            (phase schedule, cell-state/h-buffer arrays) predicts every
//            output each cycle; directed timesteps pin the model with
//            hand-computed literals, then randomized timesteps follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lstm_seq_ctrl;

    localparam int WIDTH    = 32;
    localparam int FRAC     = 24;
    localparam int NUM_X    = 4;
    localparam int NUM_H    = 1;
    localparam int SELF_IDX = 0;
    localparam int CELL_LAT = 3;
    localparam int AW       = 8;
    localparam int HAW      = (NUM_H > 1) ? $clog2(NUM_H) : 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_x_valid;
    logic [WIDTH-1:0] i_x;
    logic             o_x_ready;
    logic             i_clear;
    logic             i_h_wr;
    logic [HAW-1:0]   i_h_addr;
    logic [WIDTH-1:0] i_h_data;
    logic             o_acc_x;
    logic             o_acc_h;
    logic [WIDTH-1:0] o_cell_x;
    logic [WIDTH-1:0] o_cell_h;
    logic [WIDTH-1:0] o_prev_state;
    logic [AW-1:0]    o_w_addr;
    logic [WIDTH-1:0] i_cell_c;
    logic [WIDTH-1:0] i_cell_h;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_h;
    logic [WIDTH-1:0] o_c;
    logic             o_busy;

    lstm_seq_ctrl #(
        .WIDTH(WIDTH), .FRAC(FRAC), .NUM_X(NUM_X), .NUM_H(NUM_H),
        .SELF_IDX(SELF_IDX), .CELL_LAT(CELL_LAT), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_x_valid(i_x_valid), .i_x(i_x), .o_x_ready(o_x_ready),
        .i_clear(i_clear), .i_h_wr(i_h_wr), .i_h_addr(i_h_addr), .i_h_data(i_h_data),
        .o_acc_x(o_acc_x), .o_acc_h(o_acc_h), .o_cell_x(o_cell_x), .o_cell_h(o_cell_h),
        .o_prev_state(o_prev_state), .o_w_addr(o_w_addr),
        .i_cell_c(i_cell_c), .i_cell_h(i_cell_h),
        .o_valid(o_valid), .i_ready(i_ready), .o_h(o_h), .o_c(o_c), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [WIDTH-1:0] m_state;
    logic [WIDTH-1:0] m_oh;
    logic [WIDTH-1:0] m_oc;
    logic [WIDTH-1:0] m_hbuf [NUM_H];
    logic             p_capt;
    logic             p_clear;
    logic             rand_en;

    // ---------------- per-cycle expectations ----------------
    logic             e_chk;
    logic             e_acc_x, e_acc_h, e_xrdy, e_busy, e_valid;
    logic             e_ckx, e_ckh, e_dchk;
    logic [WIDTH-1:0] e_cell_x, e_cell_h, e_oh, e_oc, e_prev;
    logic [AW-1:0]    e_waddr;

    // sampled values for literal pins
    int               lat;
    logic [WIDTH-1:0] s_oc, s_oh, s_prev, s_cellh;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Captured cell state: optionally saturated to +/-4.0
    function automatic logic [WIDTH-1:0] capt_c(input logic [WIDTH-1:0] c);
`ifdef LSTM_STATE_CLAMP_EN
        longint v;
        longint lim;
        v   = longint'($signed(c));
        lim = 64'sd4 * (64'sd1 <<< FRAC);
        if (v > lim)  v = lim;
        if (v < -lim) v = -lim;
        return v[WIDTH-1:0];
`else
        return c;
`endif
    endfunction

    // One compare process: checks every output against the expectations
    always @(negedge clk) begin
        if (e_chk) begin
            check("acc_x", 64'(o_acc_x), 64'(e_acc_x));
            check("acc_h", 64'(o_acc_h), 64'(e_acc_h));
            check("x_ready", 64'(o_x_ready), 64'(e_xrdy));
            check("busy", 64'(o_busy), 64'(e_busy));
            check("valid", 64'(o_valid), 64'(e_valid));
            check("prev_state", 64'(o_prev_state), 64'(e_prev));
            if (e_ckx) check("cell_x", 64'(o_cell_x), 64'(e_cell_x));
            if (e_ckh) check("cell_h", 64'(o_cell_h), 64'(e_cell_h));
            if (e_ckx || e_ckh) check("w_addr", 64'(o_w_addr), 64'(e_waddr));
            if (e_dchk) begin
                check("o_h", 64'(o_h), 64'(e_oh));
                check("o_c", 64'(o_c), 64'(e_oc));
            end
        end
    end

    task automatic base_exp();
        e_acc_x = 1'b0; e_acc_h = 1'b0; e_xrdy = 1'b0; e_busy = 1'b1; e_valid = 1'b0;
        e_ckx = 1'b0; e_ckh = 1'b0; e_dchk = 1'b0;
        e_cell_x = '0; e_cell_h = '0; e_waddr = '0;
        e_oh = m_oh; e_oc = m_oc; e_prev = m_state;
    endtask

    task automatic rand_side();
        if (rand_en) begin
            i_h_wr    = ($urandom_range(0, 7) == 0);
            i_h_addr  = HAW'($urandom_range(0, NUM_H - 1));
            i_h_data  = $urandom;
            i_clear   = 1'($urandom_range(0, 1));
            i_ready   = 1'($urandom_range(0, 1));
            i_x_valid = 1'($urandom_range(0, 1));
            i_x       = $urandom;
        end else begin
            i_h_wr = 1'b0; i_h_addr = '0; i_h_data = '0;
            i_clear = 1'b0; i_ready = 1'b0; i_x_valid = 1'b0; i_x = '0;
        end
        i_cell_c = $urandom;
        i_cell_h = $urandom;
    endtask

    // Close the current cycle: advance the model by what the cycle did
    task automatic cyc();
        int a;
        @(posedge clk);
        if (rst) begin
            m_state = '0; m_oh = '0; m_oc = '0;
            for (int i = 0; i < NUM_H; i++) m_hbuf[i] = '0;
        end else begin
            if (p_clear) begin
                m_state = '0;
                for (int i = 0; i < NUM_H; i++) m_hbuf[i] = '0;
            end
            if (p_capt) begin
                m_oc = capt_c(i_cell_c);
                m_state = m_oc;
                m_oh = i_cell_h;
                m_hbuf[SELF_IDX] = i_cell_h;
            end
            if (i_h_wr) begin
                a = int'(i_h_addr);
                if (a < NUM_H) m_hbuf[a] = i_h_data;
            end
        end
        p_capt = 1'b0;
        p_clear = 1'b0;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            base_exp(); rand_side();
            e_busy = 1'b0; i_x_valid = 1'b0; i_clear = 1'b0;
            cyc();
        end
    endtask

    task automatic clear_cycle();
        base_exp(); rand_side();
        e_busy = 1'b0; i_clear = 1'b1; i_h_wr = 1'b0; p_clear = 1'b1;
        cyc();
    endtask

    // One timestep: IDLE launch, NUM_X x beats (with stalls), NUM_H h beats,
    // CELL_LAT wait cycles, capture, then OUT for rdy_wait+1 cycles.
    task automatic run_step(input logic dir, input int st_pct, input int st_after,
                            input int st_n, input int rdy_wait,
                            input logic [WIDTH-1:0] cval, input logic [WIDTH-1:0] hval,
                            input logic ext_capt, input logic rst_h);
        int   k;
        int   pend;
        int   cnt;
        logic started;
        logic v;
        base_exp(); rand_side();
        e_busy = 1'b0; i_clear = 1'b0; i_x_valid = 1'b1; i_x = $urandom;
        cyc();
        k = 0; pend = 0; cnt = 0; started = 1'b0;
        while (k < NUM_X) begin
            base_exp(); rand_side();
            if (pend > 0) begin
                v = 1'b0; pend--;
            end else if (dir) begin
                v = 1'b1;
            end else begin
                v = ($urandom_range(0, 99) >= st_pct);
            end
            i_x_valid = v;
            i_x = dir ? WIDTH'((k + 1) << FRAC) : $urandom;
            e_xrdy = 1'b1; e_acc_x = v; e_ckx = 1'b1; e_cell_x = i_x; e_waddr = AW'(k);
            if (k == 0 && !started) s_prev = o_prev_state;
            if (v) begin
                if (k == st_after) pend = st_n;
                if (k == 0) started = 1'b1;
                k++;
            end
            cyc();
            if (started) cnt++;
        end
        for (int j = 0; j < NUM_H; j++) begin
            base_exp(); rand_side();
            e_acc_h = 1'b1; e_ckh = 1'b1; e_cell_h = m_hbuf[j]; e_waddr = AW'(NUM_X + j);
            if (j == 0) s_cellh = o_cell_h;
            if (rst_h) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                check("rst_busy", 64'(o_busy), 64'd0);
                check("rst_acc_h", 64'(o_acc_h), 64'd0);
                base_exp(); rand_side();
                i_x_valid = 1'b0; i_clear = 1'b0; i_h_wr = 1'b0;
                e_busy = 1'b0; e_ckx = 1'b1; e_ckh = 1'b1; e_dchk = 1'b1;
                cyc();
                return;
            end
            cyc();
            cnt++;
        end
        for (int w = 0; w < CELL_LAT; w++) begin
            base_exp(); rand_side();
            cyc();
            cnt++;
        end
        base_exp(); rand_side();
        i_cell_c = cval; i_cell_h = hval;
        if (ext_capt) begin
            i_h_wr = 1'b1; i_h_addr = HAW'(SELF_IDX); i_h_data = $urandom;
        end
        p_capt = 1'b1;
        cyc();
        cnt++;
        for (int r = 0; r <= rdy_wait; r++) begin
            base_exp(); rand_side();
            i_ready = (r == rdy_wait);
            e_valid = 1'b1; e_dchk = 1'b1;
            if (r == 0) begin
                lat = cnt; s_oc = o_c; s_oh = o_h;
            end
            cyc();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rand_en = 1'b0; e_chk = 1'b0; p_capt = 1'b0; p_clear = 1'b0;
        i_x_valid = 1'b0; i_x = '0; i_clear = 1'b0; i_h_wr = 1'b0; i_h_addr = '0;
        i_h_data = '0; i_cell_c = '0; i_cell_h = '0; i_ready = 1'b0;
        m_state = '0; m_oh = '0; m_oc = '0;
        for (int i = 0; i < NUM_H; i++) m_hbuf[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state: everything zero, IDLE
        rst = 1'b0;
        base_exp(); e_busy = 1'b0; e_ckx = 1'b1; e_ckh = 1'b1; e_dchk = 1'b1;
        e_chk = 1'b1;
        cyc();

        // Directed: x = 1.0..4.0, no stalls, cell returns c=0.5, h=0.25
        run_step(1'b1, 0, -1, 0, 0, 32'h0080_0000, 32'h0040_0000, 1'b0, 1'b0);
        check("lat_nostall", 64'(lat), 64'd9);
        check("first_cell_h", 64'(s_cellh), 64'h0);
        check("first_prev", 64'(s_prev), 64'h0);
        check("capt_c", 64'(s_oc), 64'h0080_0000);
        check("capt_h", 64'(s_oh), 64'h0040_0000);

        // Directed: 2-cycle stall after first beat, downstream waits 5 cycles
        run_step(1'b1, 0, 0, 2, 5, 32'h0010_0000, 32'h0020_0000, 1'b0, 1'b0);
        check("next_prev", 64'(s_prev), 64'h0080_0000);
        check("next_cell_h", 64'(s_cellh), 64'h0040_0000);
        check("lat_stall", 64'(lat), 64'd11);

        // Clear, then saturation probes
        clear_cycle();
        check("clear_prev", 64'(o_prev_state), 64'h0);
        run_step(1'b1, 0, -1, 0, 0, 32'h0700_0000, 32'h0011_0000, 1'b0, 1'b0);
        check("clear_cell_h", 64'(s_cellh), 64'h0);
`ifdef LSTM_STATE_CLAMP_EN
        check("clamp_pos", 64'(s_oc), 64'h0400_0000);
`else
        check("clamp_pos", 64'(s_oc), 64'h0700_0000);
`endif
        run_step(1'b1, 0, -1, 0, 1, 32'hF900_0000, 32'h0022_0000, 1'b0, 1'b0);
`ifdef LSTM_STATE_CLAMP_EN
        check("clamp_neg", 64'(s_oc), 64'hFC00_0000);
        check("clamp_prev", 64'(s_prev), 64'h0400_0000);
`else
        check("clamp_neg", 64'(s_oc), 64'hF900_0000);
        check("clamp_prev", 64'(s_prev), 64'h0700_0000);
`endif

        // External write colliding with capture, then reset during ACC_H
        run_step(1'b1, 0, -1, 0, 0, 32'h0001_0000, 32'h0002_0000, 1'b1, 1'b0);
        run_step(1'b1, 0, -1, 0, 0, 32'h0003_0000, 32'h0004_0000, 1'b0, 1'b1);

        // Randomized timesteps
        rand_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 5) == 0) clear_cycle();
            idle_cycles($urandom_range(0, 2));
            run_step(1'b0, 25, -1, 0, $urandom_range(0, 4), $urandom, $urandom,
                     1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        rand_en = 1'b0;
        idle_cycles(2);
        e_chk = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
